// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file with pending-write
// scoreboard.
//   REG_COUNT  : number of architectural registers (x0..x31)
//   SB_CNT_W   : width of each per-register pending-write counter
//   SB_CNT_MAX : saturation value of a pending-write counter
//   reg_idx_t  : architectural register index
//   A0_IDX     : index of x10 (a0), whose bit 0 feeds the ecall check
package regfile_scoreboard_pkg;
  localparam int REG_COUNT  = 32;
  localparam int SB_CNT_W   = 2;
  localparam int SB_CNT_MAX = 3;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t A0_IDX = 5'd10;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one saturating counter per architectural register,
// counting issued-but-not-yet-written-back results.
// Ports:
//   clk, arst                    clock, asynchronous active-high reset
//   rs1_addr, rs2_addr           source registers to report busy for
//   issue_valid, issue_reg_we,   issuing instruction and its destination
//   issue_rd_addr
//   flush                        drop every reservation at the next edge
//   wb_reg_we, wb_rd_addr        write-back enable and destination
//   rs1_busy, rs2_busy           source still has a pending write
//   issue_stall                  issue refused, destination counter full
//   sb_error                     registered pulse: write-back without reservation
//
// Issue handshake: an issue request (issue_valid & issue_reg_we & rd!=0) is
// taken in the same cycle exactly when issue_stall is 0; a stalled request
// leaves no trace and must be presented again by the issuer.
module reg_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  issue_valid,
  input  logic                  issue_reg_we,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr,
  input  logic                  flush,
  input  logic                  wb_reg_we,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  issue_stall,
  output logic                  sb_error
);
  localparam int NREGS = 1 << REG_ADDR_W;

  typedef logic [SB_CNT_W-1:0] cnt_t;

  cnt_t cnt_q [NREGS];
  cnt_t cnt_d [NREGS];
  logic wb_dec;
  logic issue_req;
  logic issue_acc;
  logic sb_err_d;

  always_comb begin
    // x0 is never reserved, so its counter stays 0 and cannot decrement.
    wb_dec      = wb_reg_we && (wb_rd_addr != '0) && (cnt_q[wb_rd_addr] != '0);
    issue_req   = issue_valid && issue_reg_we && (issue_rd_addr != '0);
    // A full counter can still accept when the same-cycle write-back frees a slot.
    issue_stall = issue_req && (cnt_q[issue_rd_addr] == cnt_t'(SB_CNT_MAX)) &&
                  !(wb_dec && (wb_rd_addr == issue_rd_addr));
    issue_acc   = issue_req && !issue_stall;
    // A flush makes every reservation moot, so a write-back then is not an error.
    sb_err_d    = wb_reg_we && (wb_rd_addr != '0) && (cnt_q[wb_rd_addr] == '0) && !flush;
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else begin
        if (issue_acc && (issue_rd_addr == REG_ADDR_W'(i))) cnt_d[i] = cnt_d[i] + cnt_t'(1);
        if (wb_dec && (wb_rd_addr == REG_ADDR_W'(i)))       cnt_d[i] = cnt_d[i] - cnt_t'(1);
      end
    end
  end

  // Busy drops in the cycle the last pending write-back arrives, matching the
  // write-first bypass in the register file; a same-cycle re-issue keeps it busy.
  always_comb begin
    rs1_busy = (cnt_q[rs1_addr] != '0) &&
               !((cnt_q[rs1_addr] == cnt_t'(1)) && wb_dec && (wb_rd_addr == rs1_addr) &&
                 !(issue_acc && (issue_rd_addr == rs1_addr)));
    rs2_busy = (cnt_q[rs2_addr] != '0) &&
               !((cnt_q[rs2_addr] == cnt_t'(1)) && wb_dec && (wb_rd_addr == rs2_addr) &&
                 !(issue_acc && (issue_rd_addr == rs2_addr)));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      sb_error <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_error <= sb_err_d;
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read, one-write architectural register file with write-first bypass,
// plus a pending-write scoreboard (reg_scoreboard) for hazard detection.
// Ports:
//   i_clk, i_arst                          clock, asynchronous active-high reset
//   i_rs1_addr/i_rs2_addr                  combinational read addresses
//   o_rs1_data/o_rs2_data                  read data (x0 reads 0)
//   o_rs1_busy/o_rs2_busy                  source has a pending write
//   i_issue_valid/i_issue_reg_we/
//   i_issue_rd_addr                        issuing instruction destination
//   o_issue_stall                          issue refused, rd counter saturated
//   i_flush                                discard all reservations
//   i_wb_result/i_wb_rd_addr/i_wb_reg_we   write-back port
//   o_a0_reg_lsb                           bit 0 of x10, bypassed
//   o_sb_error                             write-back without reservation pulse
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_WIDTH-1:0] o_rs1_data,
  output logic [DATA_WIDTH-1:0] o_rs2_data,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  input  logic                  i_issue_valid,
  input  logic                  i_issue_reg_we,
  input  logic [REG_ADDR_W-1:0] i_issue_rd_addr,
  output logic                  o_issue_stall,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_wb_result,
  input  logic [REG_ADDR_W-1:0] i_wb_rd_addr,
  input  logic                  i_wb_reg_we,
  output logic                  o_a0_reg_lsb,
  output logic                  o_sb_error
);
  localparam int NREGS = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] A0_ADDR = REG_ADDR_W'(A0_IDX);

  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic                  wb_write;
  logic                  bypass_en;

  assign wb_write  = i_wb_reg_we && (i_wb_rd_addr != '0);
  // While reset is held the file must read all zeros, so the bypass is muted.
  assign bypass_en = wb_write && !i_arst;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_write) begin
      regs_q[i_wb_rd_addr] <= i_wb_result;
    end
  end

  always_comb begin
    o_rs1_data = regs_q[i_rs1_addr];
    if (i_rs1_addr == '0)                              o_rs1_data = '0;
    else if (bypass_en && (i_wb_rd_addr == i_rs1_addr)) o_rs1_data = i_wb_result;

    o_rs2_data = regs_q[i_rs2_addr];
    if (i_rs2_addr == '0)                              o_rs2_data = '0;
    else if (bypass_en && (i_wb_rd_addr == i_rs2_addr)) o_rs2_data = i_wb_result;

    o_a0_reg_lsb = regs_q[A0_ADDR][0];
    if (bypass_en && (i_wb_rd_addr == A0_ADDR)) o_a0_reg_lsb = i_wb_result[0];
  end

  reg_scoreboard #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_sb (
    .clk          (i_clk),
    .arst         (i_arst),
    .rs1_addr     (i_rs1_addr),
    .rs2_addr     (i_rs2_addr),
    .issue_valid  (i_issue_valid),
    .issue_reg_we (i_issue_reg_we),
    .issue_rd_addr(i_issue_rd_addr),
    .flush        (i_flush),
    .wb_reg_we    (i_wb_reg_we),
    .wb_rd_addr   (i_wb_rd_addr),
    .rs1_busy     (o_rs1_busy),
    .rs2_busy     (o_rs2_busy),
    .issue_stall  (o_issue_stall),
    .sb_error     (o_sb_error)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;
  logic        i_clk = 1'b0;
  logic        i_arst;
  logic [4:0]  i_rs1_addr, i_rs2_addr;
  logic [63:0] o_rs1_data, o_rs2_data;
  logic        o_rs1_busy, o_rs2_busy;
  logic        i_issue_valid, i_issue_reg_we;
  logic [4:0]  i_issue_rd_addr;
  logic        o_issue_stall;
  logic        i_flush;
  logic [63:0] i_wb_result;
  logic [4:0]  i_wb_rd_addr;
  logic        i_wb_reg_we;
  logic        o_a0_reg_lsb;
  logic        o_sb_error;

  // clock / reset block
  always #5 i_clk = ~i_clk;

  regfile_scoreboard dut (
    .i_clk          (i_clk),
    .i_arst         (i_arst),
    .i_rs1_addr     (i_rs1_addr),
    .i_rs2_addr     (i_rs2_addr),
    .o_rs1_data     (o_rs1_data),
    .o_rs2_data     (o_rs2_data),
    .o_rs1_busy     (o_rs1_busy),
    .o_rs2_busy     (o_rs2_busy),
    .i_issue_valid  (i_issue_valid),
    .i_issue_reg_we (i_issue_reg_we),
    .i_issue_rd_addr(i_issue_rd_addr),
    .o_issue_stall  (o_issue_stall),
    .i_flush        (i_flush),
    .i_wb_result    (i_wb_result),
    .i_wb_rd_addr   (i_wb_rd_addr),
    .i_wb_reg_we    (i_wb_reg_we),
    .o_a0_reg_lsb   (o_a0_reg_lsb),
    .o_sb_error     (o_sb_error)
  );

  // reference model: register contents, pending-write counts, error flag
  logic [63:0] mem [32];
  int          cnt [32];
  int          nc  [32];
  bit          err_next;
  bit          err_q;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      cnt[i] = 0;
    end
    err_q = 1'b0;
  endtask

  function automatic logic [63:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (i_wb_reg_we && (i_wb_rd_addr == a)) return i_wb_result;
    return mem[a];
  endfunction

  // driver tasks
  task automatic drive(input bit iv, input bit iw, input logic [4:0] ird,
                       input bit ww, input logic [4:0] wrd, input logic [63:0] wd,
                       input bit fl, input logic [4:0] r1, input logic [4:0] r2);
    i_issue_valid   = iv;
    i_issue_reg_we  = iw;
    i_issue_rd_addr = ird;
    i_wb_reg_we     = ww;
    i_wb_rd_addr    = wrd;
    i_wb_result     = wd;
    i_flush         = fl;
    i_rs1_addr      = r1;
    i_rs2_addr      = r2;
  endtask

  // Compare the combinational outputs against the model for the inputs now applied.
  task automatic pre_edge();
    bit          dec, stall, acc;
    logic [4:0]  w, r;
    logic [63:0] a0v;
    #1;
    w     = i_wb_rd_addr;
    r     = i_issue_rd_addr;
    dec   = i_wb_reg_we && (w != 0) && (cnt[w] > 0);
    stall = i_issue_valid && i_issue_reg_we && (r != 0) && (cnt[r] == 3) && !(dec && (w == r));
    acc   = i_issue_valid && i_issue_reg_we && (r != 0) && !stall;
    nc = cnt;
    if (acc) nc[r] = nc[r] + 1;
    if (dec) nc[w] = nc[w] - 1;
    a0v = ref_read(5'd10);
    check("rs1_data", o_rs1_data, ref_read(i_rs1_addr));
    check("rs2_data", o_rs2_data, ref_read(i_rs2_addr));
    check("rs1_busy", 64'(o_rs1_busy), 64'((cnt[i_rs1_addr] != 0) && (nc[i_rs1_addr] != 0)));
    check("rs2_busy", 64'(o_rs2_busy), 64'((cnt[i_rs2_addr] != 0) && (nc[i_rs2_addr] != 0)));
    check("issue_stall", 64'(o_issue_stall), 64'(stall));
    check("a0_lsb", 64'(o_a0_reg_lsb), 64'(a0v[0]));
    err_next = i_wb_reg_we && (w != 0) && (cnt[w] == 0) && !i_flush;
  endtask

  // Advance one clock, update the model, then compare the registered error pulse.
  task automatic post_edge();
    @(posedge i_clk);
    if (i_wb_reg_we && (i_wb_rd_addr != 0)) mem[i_wb_rd_addr] = i_wb_result;
    if (i_flush) cnt = '{default: 0};
    else         cnt = nc;
    err_q = err_next;
    @(negedge i_clk);
    check("sb_error", 64'(o_sb_error), 64'(err_q));
  endtask

  task automatic step(input bit iv, input bit iw, input logic [4:0] ird,
                      input bit ww, input logic [4:0] wrd, input logic [63:0] wd,
                      input bit fl, input logic [4:0] r1, input logic [4:0] r2);
    drive(iv, iw, ird, ww, wrd, wd, fl, r1, r2);
    pre_edge();
    post_edge();
  endtask

  function automatic logic [4:0] rand_reg();
    return 5'($urandom_range(0, 11));
  endfunction

  initial begin
    // reset
    i_arst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
    #2 i_arst = 1'b1;
    #2;
    check("rst_rs1_data", o_rs1_data, 64'd0);
    check("rst_rs2_data", o_rs2_data, 64'd0);
    check("rst_rs1_busy", 64'(o_rs1_busy), 64'd0);
    check("rst_rs2_busy", 64'(o_rs2_busy), 64'd0);
    check("rst_stall", 64'(o_issue_stall), 64'd0);
    check("rst_a0", 64'(o_a0_reg_lsb), 64'd0);
    check("rst_sb_error", 64'(o_sb_error), 64'd0);
    @(negedge i_clk);
    i_arst = 1'b0;
    model_reset();

    // x0 and x5 read zero, then bypassed write to x5
    drive(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);
    pre_edge();
    check("x0_zero", o_rs1_data, 64'd0);
    check("x5_zero", o_rs2_data, 64'd0);
    post_edge();
    drive(0, 0, 0, 1, 5'd5, 64'hDEAD_BEEF, 0, 5'd5, 5'd0);
    pre_edge();
    check("x5_bypass", o_rs1_data, 64'hDEAD_BEEF);
    post_edge();
    step(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd5);

    // fill x7 to saturation, stall, stall released by concurrent write-back
    for (int k = 0; k < 3; k++) step(1, 1, 5'd7, 0, 0, 0, 0, 5'd7, 5'd0);
    drive(1, 1, 5'd7, 0, 0, 0, 0, 5'd7, 5'd0);
    pre_edge();
    check("x7_busy", 64'(o_rs1_busy), 64'd1);
    check("x7_stall_full", 64'(o_issue_stall), 64'd1);
    post_edge();
    drive(1, 1, 5'd7, 1, 5'd7, 64'h77, 0, 5'd7, 5'd0);
    pre_edge();
    check("x7_stall_wb", 64'(o_issue_stall), 64'd0);
    post_edge();
    drive(1, 1, 5'd7, 0, 0, 0, 0, 5'd7, 5'd0);
    pre_edge();
    check("x7_still_full", 64'(o_issue_stall), 64'd1);
    post_edge();
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 5'd7, 64'(100 + k), 0, 5'd7, 5'd0);

    // write-back to unreserved x9
    drive(0, 0, 0, 1, 5'd9, 64'h1234_5678_9ABC_DEF0, 0, 5'd0, 5'd0);
    pre_edge();
    post_edge();
    check("x9_err_pulse", 64'(o_sb_error), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
    pre_edge();
    check("x9_written", o_rs1_data, 64'h1234_5678_9ABC_DEF0);
    post_edge();
    check("x9_err_once", 64'(o_sb_error), 64'd0);

    // flush overrides a same-cycle issue
    step(1, 1, 5'd3, 0, 0, 0, 0, 5'd3, 5'd4);
    step(1, 1, 5'd4, 0, 0, 0, 0, 5'd3, 5'd4);
    step(1, 1, 5'd3, 0, 0, 0, 1, 5'd3, 5'd4);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd4);
    pre_edge();
    check("flush_x3_busy", 64'(o_rs1_busy), 64'd0);
    check("flush_x4_busy", 64'(o_rs2_busy), 64'd0);
    post_edge();

    // a0 lsb with bypass
    drive(0, 0, 0, 1, 5'd10, 64'h1, 0, 5'd0, 5'd0);
    pre_edge();
    check("a0_set", 64'(o_a0_reg_lsb), 64'd1);
    post_edge();
    drive(0, 0, 0, 1, 5'd10, 64'h2, 0, 5'd0, 5'd0);
    pre_edge();
    check("a0_clr", 64'(o_a0_reg_lsb), 64'd0);
    post_edge();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) != 0), rand_reg(),
           bit'($urandom_range(0, 1)), rand_reg(), {$urandom, $urandom},
           bit'($urandom_range(0, 19) == 0), rand_reg(), rand_reg());
    end

    // asynchronous reset between edges with live reservations
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0);
    step(0, 0, 0, 1, 5'd12, 64'hCAFE_F00D, 0, 5'd12, 5'd0);
    step(1, 1, 5'd12, 0, 0, 0, 0, 5'd12, 5'd0);
    step(1, 1, 5'd12, 0, 0, 0, 0, 5'd12, 5'd0);
    step(0, 0, 0, 1, 5'd10, 64'h3, 0, 5'd12, 5'd10);
    step(0, 0, 0, 1, 5'd9, 64'h99, 0, 5'd12, 5'd10);
    drive(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd10);
    #1;
    check("pre_arst_busy", 64'(o_rs1_busy), 64'd1);
    check("pre_arst_a0", 64'(o_a0_reg_lsb), 64'd1);
    #1 i_arst = 1'b1;
    #1;
    check("arst_rs1_data", o_rs1_data, 64'd0);
    check("arst_rs1_busy", 64'(o_rs1_busy), 64'd0);
    check("arst_a0", 64'(o_a0_reg_lsb), 64'd0);
    check("arst_sb_error", 64'(o_sb_error), 64'd0);
    model_reset();
    @(negedge i_clk);
    i_arst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd10);
    check("post_arst_no_err", 64'(o_sb_error), 64'd0);
    step(1, 1, 5'd12, 0, 0, 0, 0, 5'd12, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0, 5'd12, 5'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
